// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg: shared state encoding and line geometry for bus_mem_responder.
package bus_mem_pkg;

    typedef enum logic [2:0] {IDLE, ACK, WDATA, WAIT, RESP} state_e;

    localparam int BURST_LEN        = 8;
    localparam int LINE_OFFSET_BITS = 6;

    // The write flag is always the top tag bit, whatever the tag width.
    function automatic int write_tag_bit(input int tag_width);
        return tag_width - 1;
    endfunction

    localparam int WRITE_TAG_BIT = write_tag_bit(13);

endpackage

// File: rtl/bus_mem_array.sv
// bus_mem_array: single-port backing store, synchronous write, registered read.
module bus_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 4096
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: 8-beat line memory target with fixed read latency.
// Define BUS_MEM_WRITE_RESP_EN to give each write a single zero-data response beat.
module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respack,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int WB = write_tag_bit(BUS_TAG_WIDTH);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    state_e                     state_q;
    logic [AW-4:0]              line_q;
    logic [BUS_TAG_WIDTH-1:0]   tag_q;
    logic [2:0]                 beat_q, beat_d;
    logic [3:0]                 lat_q;
    logic                       reqack_q, respcyc_q;
    logic                       is_wr;
    logic                       mem_we;
    logic [AW-1:0]              mem_addr;
    logic [BUS_DATA_WIDTH-1:0]  mem_rdata;

    assign is_wr = tag_q[WB];

    // Reads look one beat ahead so the registered array output lines up with RESP.
    always_comb begin
        beat_d   = (state_q == RESP) ? beat_q + {2'b0, bus_respack} : '0;
        mem_we   = (state_q == WDATA) && bus_reqcyc;
        mem_addr = {line_q, (state_q == WDATA) ? beat_q : beat_d};
    end

    bus_mem_array #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .WORDS      (MEM_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (bus_req),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
        end else begin
            reqack_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus_reqcyc) begin
                    line_q   <= bus_req[LINE_OFFSET_BITS +: AW-3];
                    tag_q    <= bus_reqtag;
                    reqack_q <= 1'b1;
                    state_q  <= ACK;
                end
                ACK: begin
                    beat_q  <= '0;
                    lat_q   <= 4'(READ_LATENCY - 1);
                    state_q <= is_wr ? WDATA : WAIT;
                end
                WDATA: if (bus_reqcyc) begin
                    beat_q <= beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
`ifdef BUS_MEM_WRITE_RESP_EN
                        respcyc_q <= 1'b1;
                        state_q   <= RESP;
`else
                        state_q   <= IDLE;
`endif
                    end
                end
                WAIT: if (lat_q == '0) begin
                    beat_q    <= '0;
                    respcyc_q <= 1'b1;
                    state_q   <= RESP;
                end else begin
                    lat_q <= lat_q - 4'd1;
                end
                RESP: if (bus_respack) begin
                    beat_q <= beat_d;
                    if (is_wr || beat_q == LAST_BEAT) begin
                        respcyc_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = (respcyc_q && !is_wr) ? mem_rdata : '0;
    assign bus_resptag = respcyc_q ? tag_q : '0;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed scoreboard bench for bus_mem_responder.
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_reqcyc = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_respack = 1'b0;
    logic        bus_reqack, bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    bus_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respack (bus_respack),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [12:0] t;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] model [4096];
    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    int          stall_tab[8] = '{default: 0};
    logic        respack_idle = 1'b1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic int word_of(input logic [63:0] a, input int b);
        logic [63:0] w;
        w = ((a >> 6) << 3) + 64'(b);
        return int'(w[11:0]);
    endfunction

    // Response acceptor: per-beat stall counts come from stall_tab.
    int   ack_beat = 0;
    int   stall_left = 0;
    bit   fresh = 1'b1;
    bit   was_cyc = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (was_cyc && bus_respack) begin
                ack_beat = (ack_beat + 1) % 8;
                fresh = 1'b1;
            end
            if (bus_respcyc) begin
                if (fresh) begin
                    stall_left = stall_tab[ack_beat];
                    fresh = 1'b0;
                end
                bus_respack = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else begin
                bus_respack = respack_idle;
                ack_beat = 0;
                fresh = 1'b1;
            end
            was_cyc = bus_respcyc;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    logic        prev_cyc = 1'b0;
    logic        prev_ack = 1'b0;
    logic [63:0] prev_resp = '0;
    logic [12:0] prev_tag = '0;
    beat_t       e;
    always @(negedge clk) begin
        if (reset) begin
            prev_cyc = 1'b0;
        end else begin
            if (bus_respcyc) begin
                if (prev_cyc && !prev_ack) begin
                    chk("stall_data", bus_resp, prev_resp);
                    chk("stall_tag", 64'(bus_resptag), 64'(prev_tag));
                end
                if (bus_respack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %h tag %h, none expected", bus_resp, bus_resptag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", bus_resp, e.d);
                        chk("beat_tag", 64'(bus_resptag), 64'(e.t));
                    end
                    beats_seen++;
                end
            end else begin
                chk("idle_resp", bus_resp, 64'h0);
                chk("idle_tag", 64'(bus_resptag), 64'h0);
            end
            prev_cyc  = bus_respcyc;
            prev_ack  = bus_respack;
            prev_resp = bus_resp;
            prev_tag  = bus_resptag;
        end
    end

    task automatic do_req(input logic [63:0] addr, input logic [12:0] tag, output int lat);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus_reqack && lat < 300);
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        if (!bus_reqack) chk("reqack_timeout", 64'(bus_reqack), 64'h1);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] base, input int gap);
        int lat;
`ifdef BUS_MEM_WRITE_RESP_EN
        exp_q.push_back('{d: 64'h0, t: tag});
`endif
        do_req(addr, tag, lat);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == gap) begin
                bus_reqcyc = 1'b0;
                bus_req    = '1;
                @(posedge clk); #1;
            end
            bus_reqcyc = 1'b1;
            bus_req    = base + 64'(i);
        end
        @(posedge clk); #1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        for (int i = 0; i < 8; i++) model[word_of(addr, i)] = base + 64'(i);
    endtask

    task automatic push_read(input logic [63:0] addr, input logic [12:0] tag);
        for (int i = 0; i < 8; i++) exp_q.push_back('{d: model[word_of(addr, i)], t: tag});
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, output int lat);
        push_read(addr, tag);
        do_req(addr, tag, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reqack", 64'(bus_reqack), 64'h0);
        chk("rst_respcyc", 64'(bus_respcyc), 64'h0);
        chk("rst_resp", bus_resp, 64'h0);
        chk("rst_resptag", 64'(bus_resptag), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_reqack", 64'(bus_reqack), 64'h0);
        chk("post_rst_respcyc", 64'(bus_respcyc), 64'h0);

        // Fill line 0x1040 (words 0x208..0x20F), then read it back with latency checks.
        do_write(64'h1040, 13'h1005, 64'h1000, 8);
        drain();
        do_read(64'h1040, 13'h0005, lat);
        chk("reqack_latency", 64'(lat), 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus_respcyc && n < 50);
        chk("resp_latency", 64'(n), 64'd5);
        drain();

        // Write with a stalled beat, then read back, ignoring offset bits and wrapping.
        do_write(64'h80, 13'h1003, 64'hA0, 4);
        drain();
        exp_q.push_back('{d: 64'hA0, t: 13'h0003});
        for (int i = 1; i < 8; i++) exp_q.push_back('{d: 64'hA0 + 64'(i), t: 13'h0003});
        do_req(64'h80, 13'h0003, lat);
        drain();
        do_read(64'h9F, 13'h0001, lat);
        drain();
        do_read(64'h40080, 13'h0004, lat);
        drain();

        // Backpressure on beats 2 and 5.
        stall_tab[2] = 3;
        stall_tab[5] = 3;
        b0 = beats_seen;
        do_read(64'h1040, 13'h0009, lat);
        drain();
        chk("bp_beat_count", 64'(beats_seen - b0), 64'd8);
        stall_tab = '{default: 0};

        // Second request raised during WAIT is held off until the first burst ends.
        b0 = beats_seen;
        do_read(64'h80, 13'h0021, lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_read(64'h1040, 13'h0022, lat);
        chk("busy_ack_after_burst", 64'(beats_seen - b0), 64'd8);
        drain();
        chk("busy_total_beats", 64'(beats_seen - b0), 64'd16);

        // Reset while beat 4 is stalled aborts the burst.
        stall_tab[4] = 5;
        b0 = beats_seen;
        do_read(64'h1040, 13'h0011, lat);
        n = 0;
        while (beats_seen < b0 + 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_abort_beats", 64'(beats_seen - b0), 64'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        stall_tab = '{default: 0};
        chk("abort_respcyc", 64'(bus_respcyc), 64'h0);
        chk("abort_resp", bus_resp, 64'h0);
        chk("abort_resptag", 64'(bus_resptag), 64'h0);
        @(posedge clk); #1;
        chk("abort_respcyc_2", 64'(bus_respcyc), 64'h0);
        chk("abort_reqack", 64'(bus_reqack), 64'h0);
        do_read(64'h1040, 13'h0012, lat);
        chk("post_abort_reqack_latency", 64'(lat), 64'd1);
        drain();

        // Write response phase only exists with BUS_MEM_WRITE_RESP_EN.
        do_write(64'h100, 13'h1007, 64'hC0, 8);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_respcyc) n++;
            @(posedge clk); #1;
        end
`ifdef BUS_MEM_WRITE_RESP_EN
        chk("write_resp_cycles", 64'(n), 64'd1);
`else
        chk("write_resp_cycles", 64'(n), 64'd0);
`endif
        drain();
        do_read(64'h100, 13'h0007, lat);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, width of bus_req/bus_resp.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, width of bus_reqtag/bus_resptag.
REQ-003 Parameter MEM_WORDS, default 4096, backing store depth in BUS_DATA_WIDTH words, power of two.
REQ-004 Parameter READ_LATENCY, default 4, idle cycles between the reqack cycle and the first read beat, range 1..15.
REQ-005 Port clk, input, 1, clock.
REQ-006 Port reset, input, 1: reset, synchronous, active-high.
REQ-007 Port bus_reqcyc, input, 1: initiator request valid; it also qualifies write data beats.
REQ-008 Port bus_req, input, BUS_DATA_WIDTH: byte address in the request cycle, then write data beats.
REQ-009 Port bus_reqtag, input, BUS_TAG_WIDTH: tag[BUS_TAG_WIDTH-1]=1 means write, 0 means read; the low bits are opaque.
REQ-010 Port bus_respack, input, 1: initiator accepts the current response beat.
REQ-011 Port bus_reqack, output, 1: request accepted pulse.
REQ-012 Port bus_respcyc, output, 1: response beat valid.
REQ-013 Port bus_resp, output, BUS_DATA_WIDTH: response data.
REQ-014 Port bus_resptag, output, BUS_TAG_WIDTH: the captured request tag, echoed unchanged.

Function
REQ-015 States SHALL be IDLE, ACK, WDATA, WAIT, RESP.
REQ-016 IDLE with bus_reqcyc=1 at a clock edge SHALL capture the address and tag and go to ACK.
REQ-017 ACK SHALL drive bus_reqack=1 for exactly one cycle.
REQ-018 From ACK, a write SHALL go to WDATA and a read SHALL go to WAIT.
REQ-019 The line base SHALL be address[..6] with the low 6 bits ignored: 8 beats of 8 bytes.
REQ-020 Word index SHALL be (line base * 8 + beat) mod MEM_WORDS; the address wraps silently.
REQ-021 WDATA SHALL store bus_req to beat 0..7 in order, one beat per cycle in which bus_reqcyc=1.
REQ-022 Cycles in WDATA with bus_reqcyc=0 SHALL stall the beat counter.
REQ-023 After beat 7 is stored, the block SHALL go to IDLE.
REQ-024 WAIT SHALL count READ_LATENCY cycles, then go to RESP with beat=0.
REQ-025 RESP SHALL hold bus_respcyc=1, bus_resp=mem[word(beat)], and bus_resptag=the captured tag.
REQ-026 In RESP, bus_resp SHALL stay stable until bus_respack=1 is sampled.
REQ-027 bus_respack=1 in RESP SHALL advance the beat.
REQ-028 bus_respack=1 on beat 7 SHALL go to IDLE, and bus_respcyc SHALL be 0 the next cycle.
REQ-029 bus_respack outside RESP SHALL be ignored.
REQ-030 bus_reqcyc outside IDLE/WDATA SHALL be ignored: no ack, no capture; the initiator holds it until acked.
REQ-031 A read SHALL be accepted no earlier than the cycle after the preceding transaction's final beat; read-after-write to the same line SHALL return the new data.
REQ-032 Outside RESP, bus_resp and bus_resptag SHALL be 0.

Reset
REQ-033 Reset SHALL force IDLE and clear the beat and latency counters.
REQ-034 During reset and on the cycle after it, outputs bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0.
REQ-035 Reset mid-transaction SHALL abort the transaction without a response.
REQ-036 Write beats already stored before a reset SHALL remain stored; storage SHALL never be cleared by reset.

Configuration
REQ-037 Macro BUS_MEM_WRITE_RESP_EN defined: after write beat 7, the block SHALL issue one RESP beat with bus_resp=0 and the write tag, completing on bus_respack.
REQ-038 Macro BUS_MEM_WRITE_RESP_EN undefined: writes SHALL produce no response phase.

Structure
REQ-039 Package bus_mem_pkg SHALL hold the state enum, BURST_LEN=8, the WRITE_TAG_BIT index, and LINE_OFFSET_BITS=6.
REQ-040 Sub-module bus_mem_array SHALL implement the storage: single-port, synchronous write, read data registered and ready one cycle after the address.

Verification
REQ-041 Read: reqcyc with addr 0x1040, tag 0x0005 -> reqack one cycle later, respcyc after 4 more cycles, 8 beats mem[0x208..0x20F], resptag 0x0005 on every beat.
REQ-042 Write then read: write tag 0x1003 to addr 0x80 with data 0xA0..0xA7, then read 0x80 -> beats 0xA0..0xA7 in order.
REQ-043 Backpressure: respack low on beats 2 and 5 for 3 cycles each -> bus_resp stable while stalled, exactly 8 beats delivered, no beat skipped or repeated.
REQ-044 Busy: second reqcyc raised during WAIT -> no reqack until after beat 7; the request is then served normally.
REQ-045 Reset mid-RESP after beat 3: respcyc=0 the next cycle, state IDLE, and a fresh read returns the correct data.
REQ-046 With BUS_MEM_WRITE_RESP_EN: write tag 0x1007 -> one respcyc beat with data 0 and tag 0x1007; without the macro -> no respcyc.
